// File: rtl/vga_pkg.sv
// Shared VGA timing constants, frame buffer geometry and the scan FSM state type.
package vga_pkg;

  // 640x480 @ 60 Hz horizontal timing, in pixel clocks
  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  // Vertical timing, in lines
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // Half-resolution byte frame buffer: each buffer byte covers a 2x2 pixel block
  localparam int FB_W   = 320;
  localparam int FB_H   = 240;
  localparam int ADDR_W = 17;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register used to align scan-side flags with the memory read path.
module delay_line #(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             VGA_CLK,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  // Shift one stage per clock; reset loads every stage with the idle pattern
  always_ff @(posedge VGA_CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= INIT;
      end
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/frame_scan.sv
// VGA frame scanner: walks the pixel raster, fetches palette indices from a
// half-resolution frame buffer and emits pixel, blank and sync outputs aligned
// to the returned read data. MEM_LAT is expected to lie in 1..4.
module frame_scan #(
  parameter int H_VIS   = vga_pkg::H_VIS,
  parameter int H_FP    = vga_pkg::H_FP,
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BP    = vga_pkg::H_BP,
  parameter int V_VIS   = vga_pkg::V_VIS,
  parameter int V_FP    = vga_pkg::V_FP,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BP    = vga_pkg::V_BP,
  parameter int MEM_LAT = 2
) (
  input  logic                       VGA_CLK,
  input  logic                       Reset_n,
  input  logic                       enable,
  output logic [vga_pkg::ADDR_W-1:0] OCM_ADDR,
  input  logic [7:0]                 OCM_DATA,
  output logic                       RE_OCM,
  output logic [7:0]                 PixelColor,
  output logic                       blank,
  output logic                       VGA_HS,
  output logic                       VGA_VS,
  output logic                       frame_start
);

  import vga_pkg::scan_state_t;
  import vga_pkg::IDLE;
  import vga_pkg::SCAN;
  import vga_pkg::FB_W;
  import vga_pkg::ADDR_W;

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HC_W  = $clog2(H_TOT);
  localparam int VC_W  = $clog2(V_TOT);

  localparam logic [HC_W-1:0] H_LAST  = HC_W'(H_TOT - 1);
  localparam logic [HC_W-1:0] H_VIS_C = HC_W'(H_VIS);
  localparam logic [HC_W-1:0] HS_LO   = HC_W'(H_VIS + H_FP);
  localparam logic [HC_W-1:0] HS_HI   = HC_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VC_W-1:0] V_LAST  = VC_W'(V_TOT - 1);
  localparam logic [VC_W-1:0] V_VIS_C = VC_W'(V_VIS);
  localparam logic [VC_W-1:0] VS_LO   = VC_W'(V_VIS + V_FP);
  localparam logic [VC_W-1:0] VS_HI   = VC_W'(V_VIS + V_FP + V_SYNC - 1);

  scan_state_t       state_reg, state_next;
  logic [HC_W-1:0]   hc_reg;
  logic [VC_W-1:0]   vc_reg;
  logic [ADDR_W-1:0] row_base_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              line_end, frame_end;
  logic              visible, hs_int, vs_int;
  logic [2:0]        dly_bus;

  assign line_end  = (hc_reg == H_LAST);
  assign frame_end = line_end && (vc_reg == V_LAST);

  // FSM state register
  always_ff @(posedge VGA_CLK or negedge Reset_n) begin
    if (!Reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next state: start on enable, stop only once the current frame is complete
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable) state_next = SCAN;
      SCAN:    if (frame_end && !enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: raster-derived visible flag, raw syncs and the frame marker
  always_comb begin
    visible     = 1'b0;
    hs_int      = 1'b1;
    vs_int      = 1'b1;
    frame_start = 1'b0;
    if (state_reg == SCAN) begin
      visible     = (hc_reg < H_VIS_C) && (vc_reg < V_VIS_C);
      hs_int      = !((hc_reg >= HS_LO) && (hc_reg <= HS_HI));
      vs_int      = !((vc_reg >= VS_LO) && (vc_reg <= VS_HI));
      frame_start = (hc_reg == '0) && (vc_reg == '0);
    end
  end

  // Raster counters; parked at the origin whenever not scanning
  always_ff @(posedge VGA_CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      hc_reg <= '0;
      vc_reg <= '0;
    end else if (state_reg == SCAN) begin
      if (line_end) begin
        hc_reg <= '0;
        vc_reg <= (vc_reg == V_LAST) ? '0 : vc_reg + 1'b1;
      end else begin
        hc_reg <= hc_reg + 1'b1;
      end
    end else begin
      hc_reg <= '0;
      vc_reg <= '0;
    end
  end

  // Row base tracks (vc>>1)*FB_W: two display lines share one buffer row
  always_ff @(posedge VGA_CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      row_base_reg <= '0;
    end else if (state_reg != SCAN || frame_end) begin
      row_base_reg <= '0;
    end else if (line_end && vc_reg[0] && (vc_reg < V_VIS_C)) begin
      row_base_reg <= row_base_reg + ADDR_W'(FB_W);
    end
  end

  // Read address for visible pixels; holds its last value during blanking
  always_ff @(posedge VGA_CLK or negedge Reset_n) begin
    if (!Reset_n)     addr_reg <= '0;
    else if (visible) addr_reg <= row_base_reg + ADDR_W'(hc_reg >> 1);
  end

  assign OCM_ADDR = addr_reg;

  // One stage for the address register plus MEM_LAT for the memory itself
  delay_line #(
    .WIDTH (3),
    .DEPTH (MEM_LAT + 1),
    .INIT  (3'b011)
  ) u_align (
    .VGA_CLK (VGA_CLK),
    .Reset_n (Reset_n),
    .din     ({visible, hs_int, vs_int}),
    .dout    (dly_bus)
  );

  // Output register: capture read data and the matching delayed flags together
  always_ff @(posedge VGA_CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      PixelColor <= 8'h00;
      RE_OCM     <= 1'b0;
      blank      <= 1'b0;
      VGA_HS     <= 1'b1;
      VGA_VS     <= 1'b1;
    end else begin
      PixelColor <= dly_bus[2] ? OCM_DATA : 8'h00;
      RE_OCM     <= dly_bus[2];
      blank      <= dly_bus[2];
      VGA_HS     <= dly_bus[1];
      VGA_VS     <= dly_bus[0];
    end
  end

endmodule

// File: tb/tb_frame_scan.sv
// Directed bench for frame_scan: a default-timing instance for line-level
// checks, and three reduced-raster instances (MEM_LAT 2, 1, 4) run over whole frames.
module tb_frame_scan;

  // Reduced raster: 24 clocks per line, 12 lines per frame
  localparam int S_HT     = 24;
  localparam int S_VT     = 12;
  localparam int S_FRAME  = S_HT * S_VT;
  localparam int S_FRAMES = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic Reset_n;
  logic enable_d, enable_s;

  // Default-timing instance, MEM_LAT=2, memory returns addr[7:0]^8'h5A
  logic [16:0] addr_d;
  logic [7:0]  data_d, pix_d;
  logic        re_d, blank_d, hs_d, vs_d, fs_d;
  logic [7:0]  mem_d [2];

  frame_scan u_dut_d (
    .VGA_CLK(clk), .Reset_n(Reset_n), .enable(enable_d),
    .OCM_ADDR(addr_d), .OCM_DATA(data_d), .RE_OCM(re_d), .PixelColor(pix_d),
    .blank(blank_d), .VGA_HS(hs_d), .VGA_VS(vs_d), .frame_start(fs_d)
  );

  always_ff @(posedge clk) begin
    mem_d[0] <= addr_d[7:0] ^ 8'h5A;
    mem_d[1] <= mem_d[0];
  end
  assign data_d = mem_d[1];

  // Reduced-raster instances; memory models return addr[7:0]
  logic [16:0] addr_s, addr_1, addr_4;
  logic [7:0]  data_s, data_1, data_4, pix_s, pix_1, pix_4;
  logic        re_s, blank_s, hs_s, vs_s, fs_s;
  logic        re_1, blank_1, hs_1, vs_1, fs_1;
  logic        re_4, blank_4, hs_4, vs_4, fs_4;
  logic [7:0]  mem_s [2];
  logic [7:0]  mem_1;
  logic [7:0]  mem_4 [4];

  frame_scan #(.H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
               .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(1), .MEM_LAT(2)) u_dut_s (
    .VGA_CLK(clk), .Reset_n(Reset_n), .enable(enable_s),
    .OCM_ADDR(addr_s), .OCM_DATA(data_s), .RE_OCM(re_s), .PixelColor(pix_s),
    .blank(blank_s), .VGA_HS(hs_s), .VGA_VS(vs_s), .frame_start(fs_s)
  );

  frame_scan #(.H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
               .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(1), .MEM_LAT(1)) u_dut_1 (
    .VGA_CLK(clk), .Reset_n(Reset_n), .enable(enable_s),
    .OCM_ADDR(addr_1), .OCM_DATA(data_1), .RE_OCM(re_1), .PixelColor(pix_1),
    .blank(blank_1), .VGA_HS(hs_1), .VGA_VS(vs_1), .frame_start(fs_1)
  );

  frame_scan #(.H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
               .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(1), .MEM_LAT(4)) u_dut_4 (
    .VGA_CLK(clk), .Reset_n(Reset_n), .enable(enable_s),
    .OCM_ADDR(addr_4), .OCM_DATA(data_4), .RE_OCM(re_4), .PixelColor(pix_4),
    .blank(blank_4), .VGA_HS(hs_4), .VGA_VS(vs_4), .frame_start(fs_4)
  );

  always_ff @(posedge clk) begin
    mem_s[0] <= addr_s[7:0];
    mem_s[1] <= mem_s[0];
    mem_1    <= addr_1[7:0];
    mem_4[0] <= addr_4[7:0];
    for (int i = 1; i < 4; i++) mem_4[i] <= mem_4[i-1];
  end
  assign data_s = mem_s[1];
  assign data_1 = mem_1;
  assign data_4 = mem_4[3];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int base  = 0;
  int fs_cnt_d = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (fs_d) fs_cnt_d++;
  endtask

  task automatic run_to(input int n);
    while (cyc - base < n) step();
  endtask

  // Expected {RE_OCM, blank, HS, VS, PixelColor} for reduced-raster counter cycle m
  function automatic logic [11:0] exp_out(input int m);
    int hc, vc, addr;
    logic vis, hs, vs;
    logic [7:0] pix;
    if (m < 0 || m >= S_FRAMES * S_FRAME) return {1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
    hc   = m % S_HT;
    vc   = (m / S_HT) % S_VT;
    vis  = (hc < 16) && (vc < 8);
    addr = (vc / 2) * 320 + hc / 2;
    pix  = vis ? addr[7:0] : 8'h00;
    hs   = !(hc >= 18 && hc <= 21);
    vs   = !(vc >= 9 && vc <= 10);
    return {vis, vis, hs, vs, pix};
  endfunction

  function automatic int exp_addr(input int m);
    int hc, vc;
    hc = m % S_HT;
    vc = (m / S_HT) % S_VT;
    return (vc / 2) * 320 + hc / 2;
  endfunction

  initial begin
    int hs_lo, vs_lo, first_lo, fs_cnt_s, max_addr;
    logic [11:0] e;

    // ---------------- reset state ----------------
    Reset_n  = 1'b0;
    enable_d = 1'b0;
    enable_s = 1'b0;
    repeat (3) step();
    check("rst_addr",  32'(addr_d),  32'h0);
    check("rst_pix",   32'(pix_d),   32'h0);
    check("rst_re",    32'(re_d),    32'h0);
    check("rst_blank", 32'(blank_d), 32'h0);
    check("rst_hs",    32'(hs_d),    32'h1);
    check("rst_vs",    32'(vs_d),    32'h1);
    check("rst_fs",    32'(fs_d),    32'h0);
    Reset_n = 1'b1;
    repeat (2) step();
    check("idle_fs",    32'(fs_d),    32'h0);
    check("idle_blank", 32'(blank_d), 32'h0);

    // ---------------- default timing: start of scan ----------------
    enable_d = 1'b1;
    step();
    base = cyc;
    check("fs_first",  32'(fs_d), 32'h1);
    run_to(1);
    check("fs_single", 32'(fs_d),   32'h0);
    check("addr_00",   32'(addr_d), 32'h0);
    run_to(3);
    check("pre_blank", 32'(blank_d), 32'h0);
    check("pre_pix",   32'(pix_d),   32'h0);
    run_to(4);
    check("first_blank", 32'(blank_d), 32'h1);
    check("first_re",    32'(re_d),    32'h1);
    check("first_pix",   32'(pix_d),   32'h5A);

    // ---------------- addressing ----------------
    run_to(802);
    check("addr_h1v1", 32'(addr_d), 32'd0);
    run_to(804);
    check("addr_h3v1", 32'(addr_d), 32'd1);
    run_to(1603);
    check("addr_h2v2", 32'(addr_d), 32'd321);
    run_to(1606);
    check("pix_h2v2",  32'(pix_d),  32'h1B);
    run_to(2241);
    check("addr_h640", 32'(addr_d), 32'd639);
    run_to(2242);
    check("addr_hold", 32'(addr_d), 32'd639);
    run_to(2243);
    check("pix_h639",   32'(pix_d),   32'h25);
    check("blank_h639", 32'(blank_d), 32'h1);
    run_to(2244);
    check("pix_h640",   32'(pix_d),   32'h00);
    check("blank_h640", 32'(blank_d), 32'h0);
    check("re_h640",    32'(re_d),    32'h0);

    // ---------------- horizontal sync over output line 3 ----------------
    run_to(2404);
    hs_lo = 0; vs_lo = 0; first_lo = -1;
    while (cyc - base < 3204) begin
      if (!hs_d) begin
        hs_lo++;
        if (first_lo < 0) first_lo = cyc - base;
      end
      if (!vs_d) vs_lo++;
      step();
    end
    check("hs_width", 32'(hs_lo),    32'd96);
    check("hs_start", 32'(first_lo), 32'd3060);
    check("vs_line3", 32'(vs_lo),    32'd0);
    run_to(3400);
    check("fs_count", 32'(fs_cnt_d), 32'd1);

    // ---------------- asynchronous reset mid-frame (hc=300, vc=4) ----------------
    run_to(3500);
    check("pre_rst_blank", 32'(blank_d), 32'h1);
    check("pre_rst_pix",   32'(pix_d),   32'h4E);
    Reset_n = 1'b0;
    #1;
    check("arst_addr",  32'(addr_d),  32'h0);
    check("arst_pix",   32'(pix_d),   32'h0);
    check("arst_re",    32'(re_d),    32'h0);
    check("arst_blank", 32'(blank_d), 32'h0);
    check("arst_hs",    32'(hs_d),    32'h1);
    check("arst_vs",    32'(vs_d),    32'h1);
    check("arst_fs",    32'(fs_d),    32'h0);
    repeat (2) step();
    check("arst_hold_blank", 32'(blank_d), 32'h0);
    Reset_n = 1'b1;
    step();
    base = cyc;
    check("restart_fs", 32'(fs_d), 32'h1);
    run_to(1);
    check("restart_addr", 32'(addr_d), 32'h0);
    run_to(4);
    check("restart_blank", 32'(blank_d), 32'h1);
    check("restart_pix",   32'(pix_d),   32'h5A);

    // ---------------- reduced raster: full frames, mid-frame disable ----------------
    enable_s = 1'b1;
    step();
    base = cyc;
    hs_lo = 0; vs_lo = 0; fs_cnt_s = 0; max_addr = 0;
    for (int n = 0; n < S_FRAMES * S_FRAME + 60; n++) begin
      if (n == S_FRAME + 4 * S_HT) enable_s = 1'b0;
      e = exp_out(n - 4);
      check("lat2_out", 32'({re_s, blank_s, hs_s, vs_s, pix_s}), 32'(e));
      e = exp_out(n - 3);
      check("lat1_out", 32'({re_1, blank_1, hs_1, vs_1, pix_1}), 32'(e));
      e = exp_out(n - 6);
      check("lat4_out", 32'({re_4, blank_4, hs_4, vs_4, pix_4}), 32'(e));
      check("lat2_fs", 32'(fs_s), 32'((n < S_FRAMES * S_FRAME) && (n % S_FRAME == 0)));
      if (n >= 1) begin
        e = exp_out(n - 1);
        if (e[10]) check("lat2_addr", 32'(addr_s), 32'(exp_addr(n - 1)));
      end
      if (!hs_s) hs_lo++;
      if (!vs_s) vs_lo++;
      if (fs_s) fs_cnt_s++;
      if (32'(addr_s) > max_addr) max_addr = 32'(addr_s);
      step();
    end
    check("s_hs_total", 32'(hs_lo),    32'd96);
    check("s_vs_total", 32'(vs_lo),    32'd96);
    check("s_fs_total", 32'(fs_cnt_s), 32'd2);
    check("s_max_addr", 32'(max_addr), 32'd967);
    check("s_addr_idle_hold", 32'(addr_s), 32'd967);
    check("s_idle_syncs", 32'({hs_s, vs_s, blank_s}), 32'b110);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_scan.md
FRAME_SCAN -- requirements
Module: frame_scan

Interface
REQ-001 Parameter H_VIS, default 640, visible pixels per line.
REQ-002 Parameter H_FP/H_SYNC/H_BP, default 16/96/48, horizontal porch and sync widths, giving H_TOTAL 800.
REQ-003 Parameter V_VIS, default 480, visible lines per frame.
REQ-004 Parameter V_FP/V_SYNC/V_BP, default 10/2/33, vertical porch and sync widths, giving V_TOTAL 525.
REQ-005 Parameter MEM_LAT, default 2, OCM read latency in cycles, legal range 1..4.
REQ-006 Port VGA_CLK, input, 1, pixel clock. The block has one clock; reset is asynchronous and active-low.
REQ-007 Port Reset_n, input, 1, asynchronous active-low reset.
REQ-008 Port enable, input, 1, level request to scan frames.
REQ-009 Port OCM_ADDR, output, 17, frame buffer read address for a 320x240 byte buffer.
REQ-010 Port OCM_DATA, input, 8, palette index returned MEM_LAT cycles after OCM_ADDR.
REQ-011 Port RE_OCM, output, 1, read-enable, aligned with PixelColor.
REQ-012 Port PixelColor, output, 8, palette index to the downstream palette stage.
REQ-013 Port blank, output, 1, 1 = visible pixel, 0 = blanking, aligned with PixelColor.
REQ-014 Port VGA_HS and VGA_VS, outputs, 1 each, active-low syncs, aligned with PixelColor.
REQ-015 Port frame_start, output, 1, one-cycle pulse, undelayed, when the counters are at (0,0) in SCAN.

Function
REQ-016 The FSM has two states, IDLE and SCAN.
REQ-017 IDLE -> SCAN on the first cycle enable=1; hc and vc start at 0 on the next cycle.
REQ-018 SCAN -> IDLE only at the last pixel of a frame (hc=799, vc=524) with enable=0; a mid-frame deassert completes the current frame.
REQ-019 In SCAN, hc counts 0..H_TOTAL-1 and wraps to 0; vc increments at hc wrap and wraps 0 after V_TOTAL-1.
REQ-020 In IDLE, hc and vc are held at 0, the internal read is 0, and the internal syncs are high.
REQ-021 Internal visible flag = SCAN & hc<H_VIS & vc<V_VIS; the internal read equals visible.
REQ-022 Internal HS is low for hc in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], i.e. 656..751.
REQ-023 Internal VS is low for vc in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], i.e. 490..491.
REQ-024 OCM_ADDR = (vc>>1)*320 + (hc>>1), registered, presented the cycle after the counter value.
REQ-025 OCM_ADDR is generated incrementally with a row-base register; no multiplier.
REQ-026 The row base advances by 320 at the end of each odd visible line, holds on even lines, and clears at frame wrap.
REQ-027 OCM_ADDR holds its last value outside the visible region; the maximum address is 76799.
REQ-028 visible, HS and VS pass through a delay line of MEM_LAT+1 stages, so they align with PixelColor.
REQ-029 PixelColor <= OCM_DATA when the delayed visible is 1, otherwise 8'h00.
REQ-030 RE_OCM and blank both equal the delayed visible flag.
REQ-031 Total latency from a counter value to its PixelColor/blank/sync output is MEM_LAT+2 cycles.
REQ-032 After a SCAN -> IDLE transition, the delay line drains naturally; outputs then settle to idle values.

Reset
REQ-033 Reset_n=0 asynchronously forces the following: state IDLE, hc=vc=0, row base 0, OCM_ADDR 0, PixelColor 0, RE_OCM 0, blank 0, VGA_HS 1, VGA_VS 1, frame_start 0, all delay-line stages to their idle values.
REQ-034 Reset mid-frame abandons the frame; scanning restarts at (0,0) only via REQ-017.
REQ-035 Reset release is synchronous to VGA_CLK externally; the block assumes no internal synchroniser.

Structure
REQ-036 A shared package vga_pkg holds:
- the timing constants (H_*, V_*, H_TOTAL, V_TOTAL);
- FB_W=320, FB_H=240, ADDR_W=17;
- a scan_state_t enum {IDLE, SCAN}.
REQ-037 One sub-module, delay_line (parameterised width and depth, async active-low reset to a parameterised init value), carries visible, HS and VS.

Verification
REQ-038 Reset then enable=1 -> frame_start pulses once; first OCM_ADDR=0; PixelColor=OCM_DATA, blank=1 at MEM_LAT+2 cycles after counters reach (0,0).
REQ-039 Addressing:
- hc=1,vc=1 -> addr 0;
- hc=2,vc=2 -> addr 321;
- hc=639,vc=479 -> addr 76799;
- hc=640 -> addr held, blank=0 after latency, PixelColor=0.
REQ-040 Syncs -> VGA_HS low for exactly 96 cycles per line starting at delayed hc=656; VGA_VS low for exactly 2 lines (1600 cycles) per frame.
REQ-041 Mid-frame disable: enable=0 at vc=100 -> frame completes to (799,524), then IDLE; no further frame_start; syncs high after drain.
REQ-042 Reset_n pulsed at hc=300,vc=200 -> all outputs take reset values immediately and asynchronously; re-enable restarts at addr 0.
REQ-043 MEM_LAT=1 and MEM_LAT=4 builds -> the memory model with matching latency returns addr[7:0]; each PixelColor equals its address low byte across a full frame.
